// File: rtl/pipe_unpack.sv
// pipe_unpack: binary32 operand unpack/classify front stage with 2-entry skid buffer; PIPE_UNPACK_DAZ_EN selects denormals-are-zero.
module pipe_unpack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] ina,
  input  logic [0:31] inb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        outs,
  output logic [0:7]  outea,
  output logic [0:7]  outeb,
  output logic [0:23] outma,
  output logic [0:23] outmb,
  output logic [0:5]  flags
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [0:70] or_q, or_d, sr_q, sr_d, rec;
  logic [0:34] ua, ub;
  logic in_ready_q, acc, drn;
  // {zero, inf, nan, exponent[8], significand[24]}
  function automatic logic [0:34] unpk(input logic [0:31] x);
    logic [0:7] e;
    logic [0:22] f;
    e = x[1:8];
    f = x[9:31];
`ifdef PIPE_UNPACK_DAZ_EN
    unpk = (e == 8'd0) ? {3'b100, 8'd0, 24'd0} :
`else
    unpk = (e == 8'd0) ? ((f == 23'd0) ? {3'b100, 8'd0, 24'd0} : {3'b000, 8'd1, 1'b0, f}) :
`endif
           (e == 8'hFF) ? {1'b0, f == 23'd0, f != 23'd0, e, 1'b1, f} :
           {3'b000, e, 1'b1, f};
  endfunction
  assign ua = unpk(ina);
  assign ub = unpk(inb);
  assign rec = {ina[0] ^ inb[0], ua[3:10], ub[3:10], ua[11:34], ub[11:34], ua[0:2], ub[0:2]};
  assign out_valid = state_q != EMPTY;
  assign in_ready = in_ready_q;
  assign acc = in_valid & in_ready_q;
  assign drn = out_valid & out_ready;
  assign {outs, outea, outeb, outma, outmb, flags} = or_q;
  always_comb begin
    state_d = state_q;
    or_d = or_q;
    sr_d = sr_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        or_d = rec;
      end
      ONE: if (acc && drn) or_d = rec;
      else if (acc) begin
        state_d = FULL;
        sr_d = rec;
      end else if (drn) state_d = EMPTY;
      FULL: if (drn) begin
        state_d = ONE;
        or_d = sr_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      or_q <= '0;
      sr_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      or_q <= or_d;
      sr_q <= sr_d;
      in_ready_q <= state_d != FULL;
    end
  end
endmodule

// File: doc/pipe_unpack.md
# pipe_unpack

Front stage of the pipelined single-precision floating-point multiplier, and the counterpart of the final packing stage. It accepts two IEEE-754 binary32 operands over a valid/ready handshake and splits each into sign, biased exponent and 24-bit significand with the hidden bit restored. It also classifies each operand (zero, infinity, NaN) and registers everything into the first pipeline stage. A 2-entry skid buffer decouples upstream ready from downstream back-pressure.

## Interface
Parameters:
- none; widths are fixed by binary32.

Ports (all vectors MSB-first, `[0:N-1]`; bit 0 = MSB):
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  stage can accept a pair.
- `ina`  in  32  operand A: bit 0 sign, [1:8] exponent, [9:31] fraction.
- `inb`  in  32  operand B, same layout.
- `out_valid`  out  1  unpacked pair valid.
- `out_ready`  in  1  next stage accepts.
- `outs`  out  1  product sign = sign(A) XOR sign(B).
- `outea`, `outeb`  out  8  biased exponents of A and B.
- `outma`, `outmb`  out  24  significands; bit 0 = hidden bit.
- `flags`  out  6  {zeroA, infA, nanA, zeroB, infB, nanB}.

## Operation
- Per operand, with e = exponent field and f = fraction:
  - e=0, f=0: zero=1, significand 0, exponent 0.
  - e=0, f≠0 (denormal): handled as set in Configuration.
  - 1≤e≤254: significand = {1, f}, exponent = e.
  - e=255, f=0: inf=1, significand = {1, f}.
  - e=255, f≠0: nan=1, significand = {1, f}.
- At most one of zero/inf/nan is set per operand.
- `outs` is always XOR of the raw sign bits, including for NaN.
- Datapath storage: output register (OR) plus one skid register (SR); each holds the full unpacked record.
- Registered states: EMPTY (OR invalid), ONE (OR valid, SR empty), FULL (both valid).
- Transitions (accept = `in_valid & in_ready`, drain = `out_valid & out_ready`):
  - EMPTY: accept → ONE, with OR loaded.
  - ONE: accept only → FULL, with SR loaded. Drain only → EMPTY. Accept and drain together → ONE, with OR loaded with the new pair.
  - FULL: drain → ONE, with OR loaded from SR. No accept is possible in FULL.
- Ordering is strictly FIFO; no pair is dropped or duplicated.
- Reset values: `out_valid`=0, `in_ready`=1, `outs`=0, `outea`/`outeb`=0, `outma`/`outmb`=0, `flags`=0, state EMPTY, SR cleared.

## Timing
- Latency: a pair accepted at edge N is on the outputs with `out_valid`=1 after edge N, if OR was free.
- `in_ready` is a register output: 1 in EMPTY and ONE, 0 in FULL. It has no combinational path from `out_ready`.
- Outputs are registered; there is no combinational path from the inputs.
- Output fields stay stable while `out_valid & !out_ready`.
- Sustained throughput is 1 pair per cycle while `out_ready` stays high.
- Reset asserted mid-operation: at the next edge both registers are discarded and the reset values apply, regardless of `in_valid`/`out_ready`.
- Inputs are don't-care while `in_valid`=0.

## Configuration
- `PIPE_UNPACK_DAZ_EN` defined (denormals-are-zero):
  - denormal operand → zero=1, significand 0, exponent 0; sign is kept in `outs`.
- `PIPE_UNPACK_DAZ_EN` undefined:
  - denormal operand → zero=0, exponent reported as 1, significand = {0, f}.
- The macro has no effect on handshake or timing.

## Test plan
- Normal pair: A=0x3FC00000 (1.5), B=0x40000000 (2.0) → one cycle later `out_valid`=1, `outs`=0, `outea`=0x7F, `outma`=0xC00000, `outeb`=0x80, `outmb`=0x800000, `flags`=0.
- Specials: A=0x80000000, B=0x7F800000 → `outs`=1, zeroA=1, infB=1. A=0x7FC00000 → nanA=1, `outma`=0xC00000.
- Denormal: A=0x00000001, B=0x3F800000.
  - With `PIPE_UNPACK_DAZ_EN`: zeroA=1, `outma`=0, `outea`=0.
  - Without it: `outea`=0x01, `outma`=0x000001, zeroA=0.
- Back-pressure: drive 5 consecutive pairs with `out_ready`=0 for 4 cycles → `in_ready` falls after the 2nd accept. On release all 5 pairs emerge in order, with no gaps while `out_ready`=1.
- Streaming: `in_valid`=`out_ready`=1 for 16 cycles with random operands → 16 outputs, 1 per cycle, each matching a reference model.
- Reset in FULL: fill both registers, assert `rst` for 1 cycle → next cycle `out_valid`=0, `in_ready`=1. The first pair after reset comes out correctly.
